stream_concat_packer: RTL

- Sequential, parametrised successor to the combinational slice/concat primitives.
- Accepts a valid/ready stream of WIDTH-bit beats and concatenates RATIO consecutive beats into one WIDTH*RATIO-bit output word.
- Beat 0 lands in the least-significant lane, the same ordering as concat in0.
- Supports early packet termination via in_last, with zero padding and a lane-keep mask. Sits between narrow producers and wide datapath consumers.

---
 rtl/stream_concat_packer.sv | 106 ++++++++++
 1 files changed

// File: rtl/stream_concat_packer.sv
// stream_concat_packer: packs RATIO consecutive WIDTH-bit stream beats into
// one WIDTH*RATIO-bit word, beat 0 in the least-significant lane. An in_last
// beat closes the word early; unused upper lanes are zero with keep cleared.
module stream_concat_packer #(
  parameter int WIDTH = 4,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]         out_keep,
  output logic                     out_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0] acc_q, acc_d;
  logic [RATIO-1:0]       keep_q, keep_d;
  logic [WIDTH*RATIO-1:0] odata_q, odata_d;
  logic [RATIO-1:0]       okeep_q, okeep_d;
  logic                   olast_q, olast_d;
  logic                   ovalid_q, ovalid_d;

  logic                   accept;
  logic                   complete;
  logic [WIDTH*RATIO-1:0] merged_data;
  logic [RATIO-1:0]       merged_keep;

  // Accept only when the output register is empty or draining this cycle.
  assign in_ready = rst_n && (!ovalid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt_q == CW'(RATIO - 1)) || in_last);

  // Accumulator with the incoming beat dropped into lane cnt.
  always_comb begin
    merged_data = acc_q;
    merged_keep = keep_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        merged_data[k*WIDTH +: WIDTH] = in_data;
        merged_keep[k]                = 1'b1;
      end
    end
  end

  // Next-state for accumulator and output register; a load beats a drain.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    keep_d   = keep_q;
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;
    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end
    if (complete) begin
      odata_d  = merged_data;
      okeep_d  = merged_keep;
      olast_d  = in_last;
      ovalid_d = 1'b1;
      acc_d    = '0;
      keep_d   = '0;
      cnt_d    = '0;
    end else if (accept) begin
      acc_d  = merged_data;
      keep_d = merged_keep;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      keep_q   <= '0;
      odata_q  <= '0;
      okeep_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      keep_q   <= keep_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_keep  = okeep_q;
  assign out_last  = olast_q;

endmodule
